// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gcd_pkg
// Purpose  : Shared handshake state encoding and datapath width for the GCD
//            initiator/responder pair.
// Revision : 1.0
// ============================================================================
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        DROP_A = 3'd2,
        SEND_B = 3'd3,
        DROP_B = 3'd4,
        DONE   = 3'd5
    } gcd_state_t;

endpackage
`default_nettype wire

// File: rtl/gcd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : gcd_initiator
// Purpose  : Ships an operand pair to a GCD responder over a four-phase
//            req/ack bus and returns the result on a valid/ready port.
//            Define GCD_INIT_TIMEOUT_EN to add the ack-wait timeout and err.
// Revision : 1.0
// ============================================================================
module gcd_initiator
    import gcd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [GCD_WIDTH-1:0] in_a,
    input  logic [GCD_WIDTH-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [GCD_WIDTH-1:0] out_c,
    output logic                 req,
    output logic [GCD_WIDTH-1:0] AB,
    input  logic                 ack,
    input  logic [GCD_WIDTH-1:0] C
`ifdef GCD_INIT_TIMEOUT_EN
    ,
    output logic                 err
`endif
);

    gcd_state_t           r_state;
    gcd_state_t           w_next;
    logic [GCD_WIDTH-1:0] r_a;
    logic [GCD_WIDTH-1:0] r_b;
    logic [GCD_WIDTH-1:0] r_result;
    logic                 r_req;
    logic                 w_req_next;
    logic                 w_accept;
    logic                 w_zero_op;
    logic                 w_timeout;

    assign w_accept  = in_valid && in_ready;
    assign w_zero_op = (in_a == '0) || (in_b == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next = w_zero_op ? DONE : SEND_A;
            SEND_A:  if (ack)       w_next = DROP_A;
            DROP_A:  if (!ack)      w_next = SEND_B;
            SEND_B:  if (ack)       w_next = DROP_B;
            DROP_B:  if (!ack)      w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
        if (w_timeout) begin
            w_next = IDLE;
        end
    end

    // req rises one cycle after entering a SEND state so AB is settled a full
    // cycle ahead of it, and drops on the same edge the state moves on.
    assign w_req_next = ((r_state == SEND_A) || (r_state == SEND_B)) && (w_next == r_state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_req    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= w_req_next;
            if (w_accept) begin
                r_a <= in_a;
                r_b <= in_b;
                if (w_zero_op) begin
                    r_result <= in_a | in_b;
                end
            end
            if ((r_state == SEND_B) && ack) begin
                r_result <= C;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_c     = out_valid ? r_result : '0;
    assign req       = r_req;

    always_comb begin
        AB = '0;
        case (r_state)
            SEND_A, DROP_A: AB = r_a;
            SEND_B, DROP_B: AB = r_b;
            default:        AB = '0;
        endcase
    end

`ifdef GCD_INIT_TIMEOUT_EN
    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;
    logic               w_bus;

    assign w_bus     = r_state inside {SEND_A, DROP_A, SEND_B, DROP_B};
    assign w_timeout = w_bus && (r_cnt == c_cnt_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_bus) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_initiator.sv
`default_nettype none
// Bench for gcd_initiator: behavioural four-phase GCD responder, directed and
// random operand pairs, scoreboarded results and bus-protocol checks.
module tb_gcd_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_c;
    logic        req;
    logic [15:0] AB;
    logic        ack;
    logic [15:0] C;
`ifdef GCD_INIT_TIMEOUT_EN
    logic        err;
`endif

    typedef struct {
        logic [15:0] c;
        int          pulses;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    exp_t        push_e;
    int          checks = 0;
    int          errors = 0;
    int          rises = 0;
    bit          rnd_mode = 1'b0;
    bit          resp_en = 1'b1;
    bit          tmo_test = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [15:0] prev_ab = 16'd0;

    gcd_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .req       (req),
        .AB        (AB),
        .ack       (ack),
        .C         (C)
`ifdef GCD_INIT_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        int x = int'(a);
        int y = int'(b);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 16'(x);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or event not expected", name);
    endtask

    // Responder: latch A, then return gcd(A, B) on C during the second ack.
    initial begin : responder
        int          rsp_phase;
        int          rsp_delay;
        logic [15:0] opa;
        bit          cond;
        ack = 1'b0;
        C   = 16'hDEAD;
        rsp_phase = 0;
        rsp_delay = 0;
        opa = 16'd0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || !resp_en) begin
                ack = 1'b0;
                C   = 16'hDEAD;
                rsp_phase = 0;
                rsp_delay = 0;
            end else begin
                cond = (rsp_phase % 2 == 1) ? !req : req;
                if (cond) begin
                    if (rsp_delay > 0) begin
                        rsp_delay--;
                    end else begin
                        case (rsp_phase)
                            0: begin opa = AB; ack = 1'b1; end
                            1: ack = 1'b0;
                            2: begin C = ref_gcd(opa, AB); ack = 1'b1; end
                            default: begin ack = 1'b0; C = 16'hDEAD; end
                        endcase
                        rsp_phase = (rsp_phase + 1) % 4;
                        rsp_delay = int'($urandom_range(0, 3));
                    end
                end
            end
        end
    end

    // Monitor: protocol checks, scoreboard push on accept, pop on output.
    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
            rises = 0;
        end else begin
            if (req && !prev_req) begin
                rises++;
                check("req_rise_ack_low", 32'(prev_ack), 32'd0);
                check("ab_setup", 32'(AB), 32'(prev_ab));
            end else if (req) begin
                check("ab_hold", 32'(AB), 32'(prev_ab));
            end
            if (in_ready || out_valid) begin
                check("ab_zero_idle_done", 32'(AB), 32'd0);
            end
`ifdef GCD_INIT_TIMEOUT_EN
            if (!tmo_test) begin
                check("err_quiet", 32'(err), 32'd0);
            end
`endif
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    note_fail("unexpected_output");
                end else begin
                    mon_e = sbq.pop_front();
                    check("out_c", 32'(out_c), 32'(mon_e.c));
                    check("req_pulses", 32'(rises), 32'(mon_e.pulses));
                end
                rises = 0;
            end
            if (in_valid && in_ready) begin
                push_e.c      = ref_gcd(in_a, in_b);
                push_e.pulses = (in_a != 16'd0 && in_b != 16'd0) ? 2 : 0;
                sbq.push_back(push_e);
            end
        end
        prev_req = req;
        prev_ab  = AB;
        prev_ack = ack;
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic drive_pair(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 400);
        if (!in_ready) note_fail("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        drive_pair(a, b);
        wait_accept();
    endtask

    task automatic wait_out();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 400);
        if (!out_valid) note_fail("out_valid_timeout");
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sbq.size() == 0 && in_ready) && n < 2000);
        if (sbq.size() != 0 || !in_ready) note_fail("drain_timeout");
    endtask

    initial begin : main
        int          n;
        int          k;
        logic [15:0] a;
        logic [15:0] b;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = 16'd0;
        in_b      = 16'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req", 32'(req), 32'd0);
        check("rst_ab", 32'(AB), 32'd0);
        check("rst_out_c", 32'(out_c), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;

        send(16'd12, 16'd18);
        send(16'd7, 16'd7);
        send(16'd1, 16'd65535);
        send(16'd0, 16'd0);
        send(16'd9, 16'd0);
        wait_drain();

        // Zero operand: result one cycle after accept, no bus activity.
        out_ready = 1'b0;
        send(16'd0, 16'd9);
        @(negedge clk);
        check("zero_path_valid", 32'(out_valid), 32'd1);
        check("zero_path_out_c", 32'(out_c), 32'd9);
        check("zero_path_req", 32'(req), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Back-pressure with a competing pair offered during the hold.
        out_ready = 1'b0;
        send(16'd12, 16'd18);
        wait_out();
        drive_pair(16'd3, 16'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_c", 32'(out_c), 32'd6);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept();
        wait_drain();

        // Reset while the B operand is being offered.
        send(16'd12, 16'd18);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req && AB == 16'd18) && n < 200);
        if (!(req && AB == 16'd18)) note_fail("send_b_not_seen");
        reset = 1'b1;
        #2;
        check("mid_rst_req", 32'(req), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_req", 32'(req), 32'd0);
        send(16'd12, 16'd18);
        wait_drain();

        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(1, 60));
            case ($urandom_range(0, 4))
                0: begin
                    a = 16'($urandom_range(0, 65535));
                    b = 16'($urandom_range(0, 65535));
                end
                1: begin
                    a = 16'd0;
                    b = 16'($urandom_range(0, 300));
                end
                default: begin
                    a = 16'(k * int'($urandom_range(1, 900)));
                    b = 16'(k * int'($urandom_range(1, 900)));
                end
            endcase
            send(a, b);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        wait_drain();
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

`ifdef GCD_INIT_TIMEOUT_EN
        // Silent responder: err pulses 16 cycles into SEND_A, back to idle.
        resp_en  = 1'b0;
        tmo_test = 1'b1;
        send(16'd12, 16'd18);
        for (int j = 0; j <= 16; j++) begin
            @(negedge clk);
            check("tmo_err", 32'(err), (j == 16) ? 32'd1 : 32'd0);
            if (j == 8) check("tmo_req_waiting", 32'(req), 32'd1);
            if (j == 16) begin
                check("tmo_req_dropped", 32'(req), 32'd0);
                check("tmo_in_ready", 32'(in_ready), 32'd1);
            end
        end
        @(negedge clk);
        check("tmo_err_single", 32'(err), 32'd0);
        check("tmo_no_result", 32'(out_valid), 32'd0);
        sbq.delete();
        rises    = 0;
        tmo_test = 1'b0;
        resp_en  = 1'b1;
        send(16'd7, 16'd7);
        wait_drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        note_fail("watchdog");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/gcd_initiator.md
GCD_INITIATOR -- requirements
Module: gcd_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: ack-wait limit in clk cycles; used only when GCD_INIT_TIMEOUT_EN is defined.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  operand pair offered.
REQ-005 in_ready  out  1  operand pair accepted when in_valid && in_ready.
REQ-006 in_a, in_b  in  16 each  unsigned operands.
REQ-007 out_valid  out  1  result available.
REQ-008 out_ready  in  1  consumer takes result when out_valid && out_ready.
REQ-009 out_c  out  16  result, gcd(in_a, in_b).
REQ-010 req  out  1  four-phase request to GCD responder.
REQ-011 AB  out  16  operand bus to responder.
REQ-012 ack  in  1  responder acknowledge, same clock domain, used unsynchronised.
REQ-013 C  in  16  responder result, valid while ack=1 during the result phase.

Function
REQ-014 States: IDLE, SEND_A, DROP_A, SEND_B, DROP_B, DONE.
REQ-015 IDLE: in_ready=1, req=0; on accept, register a, b; go to SEND_A next cycle if both nonzero, else go to DONE with out_c = a | b and no bus activity.
REQ-016 SEND_A: req=1, AB=a; on ack=1 go to DROP_A.
REQ-017 DROP_A: req=0, AB=a; on ack=0 go to SEND_B.
REQ-018 SEND_B: req=1, AB=b; on ack=1 capture C into result register, go to DROP_B.
REQ-019 DROP_B: req=0; on ack=0 go to DONE.
REQ-020 DONE: out_valid=1, out_c=result; on out_ready go to IDLE; out_c held stable while out_valid=1.
REQ-021 in_ready=0 and out_valid=0 in every state other than IDLE and DONE respectively; no operand is accepted while a result is pending.
REQ-022 AB SHALL equal the current operand for the whole time req=1, and one cycle before it rises; AB=0 in IDLE and DONE.
REQ-023 req SHALL never rise while ack=1.
REQ-024 Accept-to-req latency: 1 cycle; minimum accept-to-out_valid latency is set by the responder; the zero-operand path takes 1 cycle.

Reset
REQ-025 Reset forces state IDLE, req=0, AB=0, out_valid=0, out_c=0, in_ready=1, and clears the a, b, and result registers.
REQ-026 Reset mid-transaction abandons the transaction with no result; the responder is assumed reset by the same signal.

Configuration
REQ-027 GCD_INIT_TIMEOUT_EN defined: adds port err (out, 1) and a counter cleared on each state entry, counting cycles in SEND_A, DROP_A, SEND_B, and DROP_B.
REQ-028 When the counter reaches TIMEOUT_CYCLES, the block SHALL pulse err=1 for one cycle, drive req=0, and go to IDLE with no result.
REQ-029 GCD_INIT_TIMEOUT_EN undefined: no err port, no counter; waits on ack are unbounded.

Structure
REQ-030 Package gcd_pkg holds the state enum typedef and constant GCD_WIDTH=16, shared with the responder.
REQ-031 Single module, no sub-module; the timeout counter is inline under the macro.

Verification
REQ-032 Bench pairs with the GCD responder; in_a=12, in_b=18 -> out_c=6, one req pulse per operand.
REQ-033 in_a=7, in_b=7 -> out_c=7; in_a=1, in_b=65535 -> out_c=1.
REQ-034 in_a=0, in_b=9 -> out_c=9 one cycle after accept, req stays 0; in_a=0, in_b=0 -> out_c=0.
REQ-035 out_ready held low 5 cycles after out_valid -> out_valid and out_c (=6) held, in_ready=0 throughout.
REQ-036 Reset asserted in SEND_B -> next cycle req=0, out_valid=0, in_ready=1; the following pair 12/18 -> 6.
REQ-037 Macro defined, TIMEOUT_CYCLES=16, ack tied 0 -> err pulses once 16 cycles into SEND_A, req drops, in_ready=1.
